// File: rtl/sobel_stream_if.sv
// Pixel-in / result-out bundle for sobel_stream; one parameter sets the pixel width.
// pixel_valid qualifies sof/pixel_in in that cycle and the block always accepts (no ready);
// out_valid is a one-cycle strobe with no backpressure, out_pixel/out_edge/frame_done valid with it.
interface sobel_stream_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic                   sof;
    logic                   pixel_valid;
    logic [PIXEL_WIDTH-1:0] pixel_in;
    logic [PIXEL_WIDTH-1:0] threshold;
    logic                   mode;
    logic                   out_valid;
    logic [PIXEL_WIDTH-1:0] out_pixel;
    logic                   out_edge;
    logic                   frame_done;
    logic                   busy;
    logic                   fsm_state;

    modport master (
        output sof, pixel_valid, pixel_in, threshold, mode,
        input  out_valid, out_pixel, out_edge, frame_done, busy, fsm_state
    );

    modport slave (
        input  sof, pixel_valid, pixel_in, threshold, mode,
        output out_valid, out_pixel, out_edge, frame_done, busy, fsm_state
    );
endinterface

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel: two line buffers build the window, stage 1 forms Gx/Gy,
// stage 2 forms |Gx|+|Gy| and the edge flag / saturated magnitude.
module sobel_stream #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480
) (
    input  logic          clock,
    input  logic          reset,
    sobel_stream_if.slave bus
);
    localparam int P  = PIXEL_WIDTH;
    localparam int G  = PIXEL_WIDTH + 3;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [P-1:0]  thr_q;
    logic          mode_q;
    logic          busy_q;

    logic [P-1:0]  lb1 [IMG_WIDTH];
    logic [P-1:0]  lb2 [IMG_WIDTH];
    // Window columns c-2 / c-1 for the top (r-2), middle (r-1) and bottom (r) rows.
    logic [P-1:0]  t0, t1, m0, m1, b0, b1;

    logic          accept;
    logic [CW-1:0] acc_col;
    logic [RW-1:0] acc_row;
    logic [P-1:0]  up1, up2;
    logic          win_ok, last_col, last_row;
    logic signed [G-1:0] gx_c, gy_c;

    logic                s1_valid, s1_last, s1_mode;
    logic signed [G-1:0] s1_gx, s1_gy;
    logic [P-1:0]        s1_thr;
    logic [G-1:0]        s_sum;
    logic                edge_c;
    logic [P-1:0]        sat_c;

    logic          out_valid_q, out_edge_q, frame_done_q;
    logic [P-1:0]  out_pixel_q;

    function automatic logic signed [G-1:0] ext(input logic [P-1:0] v);
        return signed'({3'b000, v});
    endfunction

    function automatic logic [G-1:0] mag(input logic signed [G-1:0] v);
        logic [G-1:0] u;
        u = v[G-1] ? -v : v;
        return u;
    endfunction

    // A sof beat is always pixel (0,0), even when it interrupts a running frame.
    always_comb begin
        accept   = bus.pixel_valid && (bus.sof || state == RUN);
        acc_col  = bus.sof ? '0 : col;
        acc_row  = bus.sof ? '0 : row;
        up1      = lb1[acc_col];
        up2      = lb2[acc_col];
        win_ok   = accept && (acc_row >= RW'(2)) && (acc_col >= CW'(2));
        last_col = (acc_col == CW'(IMG_WIDTH - 1));
        last_row = (acc_row == RW'(IMG_HEIGHT - 1));
        gx_c = (ext(up2) + (ext(up1) <<< 1) + ext(bus.pixel_in))
             - (ext(t0)  + (ext(m0)  <<< 1) + ext(b0));
        gy_c = (ext(t0) + (ext(t1) <<< 1) + ext(up2))
             - (ext(b0) + (ext(b1) <<< 1) + ext(bus.pixel_in));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            col    <= '0;
            row    <= '0;
            thr_q  <= '0;
            mode_q <= 1'b0;
        end else if (accept) begin
            if (bus.sof) begin
                thr_q  <= bus.threshold;
                mode_q <= bus.mode;
            end
            if (last_col && last_row) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                col    <= '0;
                row    <= '0;
            end else if (last_col) begin
                state  <= RUN;
                busy_q <= 1'b1;
                col    <= '0;
                row    <= acc_row + RW'(1);
            end else begin
                state  <= RUN;
                busy_q <= 1'b1;
                col    <= acc_col + CW'(1);
                row    <= acc_row;
            end
        end
    end

    // Line buffers and window shift registers carry no reset; stale contents never reach a result.
    always_ff @(posedge clock) begin
        if (accept) begin
            lb2[acc_col] <= up1;
            lb1[acc_col] <= bus.pixel_in;
            t0 <= t1;
            t1 <= up2;
            m0 <= m1;
            m1 <= up1;
            b0 <= b1;
            b1 <= bus.pixel_in;
        end
    end

    // threshold and mode travel with each result so a restart cannot retag in-flight ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= 1'b0;
            s1_gx    <= '0;
            s1_gy    <= '0;
            s1_thr   <= '0;
        end else begin
            s1_valid <= win_ok;
            s1_last  <= win_ok && last_col && last_row;
            s1_mode  <= mode_q;
            s1_thr   <= thr_q;
            s1_gx    <= gx_c;
            s1_gy    <= gy_c;
        end
    end

    always_comb begin
        s_sum  = mag(s1_gx) + mag(s1_gy);
        edge_c = s_sum > {3'b000, s1_thr};
        sat_c  = (s_sum > {3'b000, {P{1'b1}}}) ? {P{1'b1}} : s_sum[P-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_edge_q   <= 1'b0;
            out_pixel_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= s1_valid;
            frame_done_q <= s1_valid && s1_last;
            if (s1_valid) begin
                out_edge_q  <= edge_c;
                out_pixel_q <= s1_mode ? sat_c : (edge_c ? {P{1'b1}} : '0);
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_pixel  = out_pixel_q;
    assign bus.out_edge   = out_edge_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
    assign bus.fsm_state  = state;
endmodule

// File: tb/tb_sobel_stream.sv
// Randomised bench for sobel_stream (W=8, H=6): a frame-image reference model predicts
// every result and its cycle; a negedge scoreboard compares against the DUT.
module tb_sobel_stream;
    localparam int P = 8;
    localparam int W = 8;
    localparam int H = 6;
    localparam int NRES = (H - 2) * (W - 2);

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    sobel_stream_if #(.PIXEL_WIDTH(P)) sif ();

    sobel_stream #(
        .PIXEL_WIDTH(P),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (sif)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: the frame as written so far, plus the spec's raster/latch rules.
    int          img [H][W];
    bit          m_active = 1'b0;
    int          m_r, m_c, m_thr, m_mode;
    logic [25:0] exp_q [$];   // {due cycle[15:0], frame_done, edge, pixel[7:0]}
    int          n_res, n_edge, n_done;
    bit          chk_done_pos = 1'b1;
    logic [25:0] sb_ent;

    task automatic push_expected(input int r, input int c);
        int gx, gy, s, wk, op;
        bit e, done;
        logic [25:0] ent;
        gx = 0;
        gy = 0;
        for (int k = 0; k < 3; k++) begin
            wk = (k == 1) ? 2 : 1;
            gx += wk * (img[r-2+k][c] - img[r-2+k][c-2]);
            gy += wk * (img[r-2][c-2+k] - img[r][c-2+k]);
        end
        s    = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        e    = (s > m_thr);
        op   = m_mode ? (s > 255 ? 255 : s) : (e ? 255 : 0);
        done = (r == H - 1) && (c == W - 1);
        ent[25:10] = 16'(cyc + 2);
        ent[9]     = done;
        ent[8]     = e;
        ent[7:0]   = op[7:0];
        exp_q.push_back(ent);
    endtask

    task automatic model_beat(input bit s, input int pix, input int thr, input int md);
        if (s) begin
            m_active = 1'b1;
            m_r = 0;
            m_c = 0;
            m_thr = thr;
            m_mode = md;
        end
        if (m_active) begin
            img[m_r][m_c] = pix;
            if (m_r >= 2 && m_c >= 2) push_expected(m_r, m_c);
            if (m_c == W - 1) begin
                m_c = 0;
                if (m_r == H - 1) m_active = 1'b0;
                else m_r++;
            end else begin
                m_c++;
            end
        end
    endtask

    task automatic drive(input bit s, input bit v, input int pix, input int thr, input int md);
        @(posedge clock);
        #1;
        sif.sof         = s;
        sif.pixel_valid = v;
        sif.pixel_in    = pix[P-1:0];
        sif.threshold   = thr[P-1:0];
        sif.mode        = md[0];
        if (v) model_beat(s, pix, thr, md);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0);
    endtask

    function automatic int pix_of(input int kind, input int r, input int c);
        case (kind)
            0:       return 100;
            1:       return (c < 4) ? 0 : 255;
            2:       return 10 * c;
            3:       return int'($urandom_range(255));
            default: return 77;
        endcase
    endfunction

    // Non-sof beats and gap cycles carry random threshold/mode/sof to show they are ignored.
    task automatic run_frame(input int kind, input int thr, input int md, input int gap_pct,
                             input int stop_after);
        int n, r, c;
        n = 0;
        while (n < stop_after) begin
            if (n > 0 && int'($urandom_range(99)) < gap_pct) begin
                drive(1'($urandom_range(1)), 1'b0, int'($urandom_range(255)),
                      int'($urandom_range(255)), int'($urandom_range(1)));
            end else begin
                r = n / W;
                c = n % W;
                drive(n == 0, 1'b1, pix_of(kind, r, c),
                      (n == 0) ? thr : int'($urandom_range(255)),
                      (n == 0) ? md : int'($urandom_range(1)));
                n++;
            end
        end
    endtask

    task automatic clear_counts();
        n_res  = 0;
        n_edge = 0;
        n_done = 0;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (sif.out_valid) begin
                n_res++;
                if (sif.out_edge) n_edge++;
                if (sif.frame_done) n_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", sif.out_valid, 0);
                end else begin
                    sb_ent = exp_q.pop_front();
                    check("latency", cyc[15:0], sb_ent[25:10]);
                    check("out_pixel", sif.out_pixel, sb_ent[7:0]);
                    check("out_edge", sif.out_edge, sb_ent[8]);
                    check("frame_done", sif.frame_done, sb_ent[9]);
                end
                if (sif.frame_done && chk_done_pos) check("done_on_last_result", n_res, NRES);
            end else begin
                check("frame_done_idle", sif.frame_done, 0);
                if (exp_q.size() > 0 && exp_q[0][25:10] <= cyc[15:0]) begin
                    check("missing_result", sif.out_valid, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        sif.sof         = 1'b0;
        sif.pixel_valid = 1'b0;
        sif.pixel_in    = '0;
        sif.threshold   = '0;
        sif.mode        = 1'b0;
        clear_counts();

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_out_valid", sif.out_valid, 0);
        check("reset_out_pixel", sif.out_pixel, 0);
        check("reset_out_edge", sif.out_edge, 0);
        check("reset_frame_done", sif.frame_done, 0);
        check("reset_busy", sif.busy, 0);
        check("reset_state", sif.fsm_state, 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Valid beats without sof in IDLE must be ignored.
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, int'($urandom_range(255)), 0, 1);
        idle(3);
        check("idle_ignored_busy", sif.busy, 0);
        check("idle_ignored_results", n_res, 0);

        clear_counts();
        run_frame(0, 50, 1, 0, W * H);
        idle(4);
        check("flat_results", n_res, NRES);
        check("flat_edges", n_edge, 0);
        check("flat_done", n_done, 1);
        check("flat_busy_after", sif.busy, 0);

        clear_counts();
        run_frame(1, 200, 1, 0, W * H);
        idle(4);
        check("step_results", n_res, NRES);
        check("step_edges", n_edge, 2 * (H - 2));
        check("step_done", n_done, 1);

        clear_counts();
        run_frame(2, 80, 0, 0, W * H);
        idle(4);
        check("ramp80_results", n_res, NRES);
        check("ramp80_edges", n_edge, 0);

        clear_counts();
        run_frame(2, 79, 0, 0, W * H);
        idle(4);
        check("ramp79_edges", n_edge, NRES);
        check("ramp79_done", n_done, 1);

        clear_counts();
        run_frame(1, 200, 1, 50, W * H);
        idle(4);
        check("step_gaps_results", n_res, NRES);
        check("step_gaps_edges", n_edge, 2 * (H - 2));
        check("step_gaps_done", n_done, 1);

        // Restart mid-row 3 after a short gap: the first frame must end without frame_done.
        clear_counts();
        run_frame(1, 200, 1, 0, 3 * W + 4);
        idle(3);
        check("abort_busy", sif.busy, 1);
        check("abort_no_done", n_done, 0);
        clear_counts();
        run_frame(4, 10, 1, 0, W * H);
        idle(4);
        check("restart_results", n_res, NRES);
        check("restart_edges", n_edge, 0);
        check("restart_done", n_done, 1);

        // Random frames; frame 1 is cut short and restarted with no gap.
        chk_done_pos = 1'b0;
        for (int f = 0; f < 4; f++) begin
            run_frame(3, int'($urandom_range(255)), int'($urandom_range(1)), 30,
                      (f == 1) ? 20 + int'($urandom_range(10)) : W * H);
            if (f != 1) idle(4);
        end
        chk_done_pos = 1'b1;

        // Reset mid-frame, with results still in the pipeline.
        clear_counts();
        run_frame(3, 100, 1, 0, 30);
        check("midframe_busy", sif.busy, 1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        m_active = 1'b0;
        sif.pixel_valid = 1'b0;
        #1;
        check("rst_out_valid", sif.out_valid, 0);
        check("rst_out_pixel", sif.out_pixel, 0);
        check("rst_out_edge", sif.out_edge, 0);
        check("rst_frame_done", sif.frame_done, 0);
        check("rst_busy", sif.busy, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        clear_counts();
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, int'($urandom_range(255)), 0, 1);
        idle(4);
        check("post_reset_results", n_res, 0);
        check("post_reset_busy", sif.busy, 0);

        clear_counts();
        run_frame(0, 50, 1, 20, W * H);
        idle(4);
        check("recover_results", n_res, NRES);
        check("recover_done", n_done, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sobel_stream.md
Name: sobel_stream

Overview:
Streaming 3x3 Sobel edge detector, the parametrised successor of the combinational per-window Sobel block. It accepts a raster-order pixel stream and builds the 3x3 window internally with two line buffers. It emits one result per interior pixel through a 2-stage pipeline, either as a binary edge flag or as a saturated gradient magnitude. It sits between the camera/grayscale path and the frame-buffer DMA.

Parameters:
PIXEL_WIDTH, 8, bits per grayscale pixel (P)
IMG_WIDTH, 640, pixels per line (W, min 3)
IMG_HEIGHT, 480, lines per frame (H, min 3)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high
sof  in  1  start of frame; qualifies the pixel_in beat as pixel (0,0); ignored unless pixel_valid=1
pixel_valid  in  1  pixel_in valid this cycle; no backpressure
pixel_in  in  P  grayscale pixel, raster order
threshold  in  P  edge threshold, latched on the sof beat
mode  in  1  0 = binary edge output, 1 = magnitude output; latched on the sof beat
out_valid  out  1  result valid (single-cycle strobe)
out_pixel  out  P  mode 0: all ones if edge else 0; mode 1: min(|Gx|+|Gy|, 2^P-1)
out_edge  out  1  (|Gx|+|Gy|) > threshold, independent of mode
frame_done  out  1  one-cycle pulse with the last interior result of a frame
busy  out  1  high in RUN state

Behaviour:
- Reset (async): state IDLE, row/col counters 0, out_valid=0, out_pixel=0, out_edge=0, frame_done=0, busy=0, pipeline valid bits cleared. Line buffer contents are don't-care.
- FSM IDLE: pixel_valid without sof is ignored. pixel_valid&sof latches threshold and mode, accepts the pixel as (0,0), and enters RUN.
- FSM RUN: each pixel_valid beat is written at the current col into line buffers and the window shift registers. col increments and wraps at W-1 to 0 with row+1. After accepting (H-1,W-1), return to IDLE.
- sof in RUN: restart. The beat is (0,0), threshold and mode are re-latched, and counters reset. Results already in the pipeline still emerge. No frame_done for the aborted frame.
- Gaps: pixel_valid=0 cycles stall counters and window. The pipeline still advances, so in-flight results emerge on schedule.
- Window on accepting (r,c) with r>=2, c>=2, centre (r-1,c-1):
  - p0..p2 = row r-2, cols c-2..c.
  - p3..p5 = row r-1.
  - p6..p8 = row r.
- Pixels with r<2 or c<2 produce no result. Output order is raster over rows 1..H-2 and cols 1..W-2, giving (H-2)*(W-2) results per frame.
- Stage 1 (registered): Gx = (p2+2p5+p8)-(p0+2p3+p6) and Gy = (p0+2p1+p2)-(p6+2p7+p8), each signed P+3 bits. No overflow is allowed.
- Stage 2 (registered): S = |Gx|+|Gy| as unsigned P+3 bits. out_edge = S > threshold, strictly greater. out_pixel is selected by the latched mode.
- Latency: out_valid is high exactly 2 cycles after the accepting beat's pixel_valid.
- frame_done is asserted in the same cycle as out_valid for centre (H-2,W-2).
- threshold and mode changes outside the sof beat have no effect until the next sof.
- Reset mid-frame aborts immediately. Nothing emerges afterwards until a new sof.

Test Plan:
- W=8, H=6, mode 1, constant 100 frame, continuous valid -> exactly 24 out_valid beats. All out_pixel=0 and out_edge=0. frame_done coincides with the 24th beat, 2 cycles after the last input.
- W=8, H=6, mode 1, threshold 200, cols 0-3=0, cols 4-7=255 -> for each of rows 1..4: out_pixel 0,0,255,255,0,0 for cols 1..6, with out_edge 0,0,1,1,0,0.
- Horizontal ramp pixel=10*c, mode 0: threshold 80 -> out_edge=0 and out_pixel=0 everywhere. Threshold 79 -> out_edge=1 and out_pixel=255 everywhere (S=80).
- Step frame with random pixel_valid gaps (~50% duty) -> same result sequence as the continuous case, each result 2 cycles after its accepting beat.
- sof asserted mid-row-3 with a new flat frame -> no frame_done for the first frame. Second frame yields 24 zero results, then a frame_done.
- reset asserted mid-frame -> outputs 0 and busy=0 immediately, then no out_valid. pixel_valid without sof is ignored until sof arrives.
